irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller between peripheral interrupt sources and the CPU core's irq/irq_addr inputs. Replaces the registered interrupt dummy at MCU level.
- Synchronizes and edge-detects up to NSRC sources, latches pending flags, and applies enable masks.
- Picks the highest-priority pending source, issues a one-cycle request with its vector address, then holds off further requests until software clears that source's flag.
- Configured through the CPU I/O register bus.

Parameters:
NSRC, 8, number of interrupt sources (1..8)
IO_BASE, 8'h38, I/O address of first controller register (4 consecutive addresses used)
VEC_BASE, 16'h0002, vector address of source 0
VEC_STRIDE, 2, word distance between consecutive vectors

Ports:
clock  input  1  master clock
reset_n  input  1  asynchronous active-low reset
src  input  NSRC  raw interrupt sources, asynchronous, rising-edge sensitive
io_addr  input  8  I/O register address
io_re  input  1  I/O read enable
io_we  input  1  I/O write enable
io_wdata  input  8  I/O write data
io_rdata  output  8  I/O read data, 0 when not addressed
irq  output  1  interrupt request to CPU, one-cycle pulse
irq_addr  output  16  vector address, valid with irq and held until the next request

Behaviour:
- Reset (reset_n low, asynchronous): IER=0, IFR=0, GIE=0, synchronizers=0, state IDLE, irq=0, irq_addr=16'h0000, active index=8'hFF.
- Input path: 2-flop synchronizer per src bit, then a rising-edge detector (sync2 & ~sync3). Edge sets IFR[i] 3 cycles after the src rise.
- Register map (offset from IO_BASE):
  - +0 IER: read/write. Bits >= NSRC read 0.
  - +1 IFR: read; writing 1 clears a bit (W1C); writing 0 has no effect.
  - +2 ICR: bit0 GIE read/write; bit7 BUSY read-only (state != IDLE); other bits read 0.
  - +3 ACT: read-only index of the in-service source, 8'hFF when none.
- io_rdata is combinational: register value when io_re is high and io_addr hits, else 8'h00. Writes take effect on the clock edge with io_we high.
- Same-cycle edge and W1C on the same IFR bit: set wins.
- Pending vector P = IFR & IER. Priority is fixed: lowest index wins.
- FSM:
  - IDLE: if GIE and P!=0, go to REQ. Latch winner index k into ACT. irq_addr <= VEC_BASE + k*VEC_STRIDE, computed in 16 bits with wrap.
  - REQ: irq=1 for exactly this cycle; go to SERV.
  - SERV: irq=0. Wait until IFR[k]==0 (cleared by W1C). Then ACT <= 8'hFF and go to GAP. Clearing IER[k] or GIE does not end SERV; only the IFR[k] clear does.
  - GAP: one idle cycle so the CPU can retire the clearing instruction; go to IDLE.
- Minimum spacing between irq pulses: 3 cycles (REQ, SERV >= 1, GAP).
- New edges during SERV/GAP only set IFR and are arbitrated in IDLE. A higher-priority source never preempts.
- GIE cleared while in IDLE with P!=0: no request is issued.
- Reset in any state: immediate return to the reset values; an in-flight irq pulse is truncated.
- irq is a registered output with no combinational path from src or the io_* inputs.

Decomposition:
- Shared package constants: register offsets (IER=0, IFR=1, ICR=2, ACT=3), ICR bit positions (GIE=0, BUSY=7), ACT_NONE=8'hFF, FSM state encoding (IDLE, REQ, SERV, GAP; 2-bit).
- One sub-module, irq_sync_edge: per-bit 2-flop synchronizer plus rising-edge detector, parameterized width, asynchronous active-low reset.
- Priority encoder and register file stay in irq_ctrl.

Test Plan:
- Reset, then read all four registers -> IER=00, IFR=00, ICR=00, ACT=FF; irq=0, irq_addr=0000.
- IER=01, GIE=1, raise src[0] -> IFR=01 after 3 cycles. One-cycle irq with irq_addr=0002. ACT=00, BUSY=1. Write IFR=01 -> ACT=FF, BUSY=0 two cycles later.
- IER=FF, GIE=1, raise src[5] and src[2] in the same cycle -> first irq_addr=0006 (source 2). Clear IFR bit 2 -> after GAP, second irq_addr=000C (source 5).
- GIE=0, IER=08, pulse src[3] -> IFR=08, no irq. Set GIE=1 -> irq with irq_addr=0008.
- Edge on src[1] in the same cycle as a W1C of IFR bit 1 -> IFR bit 1 remains 1.
- Assert reset_n=0 in the REQ cycle -> irq drops immediately. After release, all registers are at reset values and no irq is issued.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, ICR bit
// positions, the "no active source" marker and the FSM state encoding.
package irq_ctrl_pkg;

  localparam logic [1:0] OFF_IER = 2'd0;
  localparam logic [1:0] OFF_IFR = 2'd1;
  localparam logic [1:0] OFF_ICR = 2'd2;
  localparam logic [1:0] OFF_ACT = 2'd3;

  localparam int ICR_GIE  = 0;
  localparam int ICR_BUSY = 7;

  localparam logic [7:0] ACT_NONE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-bit two-flop synchronizer followed by a rising-edge detector; rise is
// high for one cycle, two clocks after the raw input goes high.
module irq_sync_edge #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] sync1_q, sync2_q, sync3_q;
  logic [W-1:0] sync1_d, sync2_d, sync3_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    rise    = sync2_q & ~sync3_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches synchronized source edges, masks them, and
// hands the lowest-index pending source to the CPU as a one-cycle request.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NSRC       = 8,
  parameter logic [7:0]  IO_BASE    = 8'h38,
  parameter logic [15:0] VEC_BASE   = 16'h0002,
  parameter int          VEC_STRIDE = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [NSRC-1:0] src,
  input  logic [7:0]      io_addr,
  input  logic            io_re,
  input  logic            io_we,
  input  logic [7:0]      io_wdata,
  output logic [7:0]      io_rdata,
  output logic            irq,
  output logic [15:0]     irq_addr
);

  logic [NSRC-1:0] src_rise;
  logic [NSRC-1:0] ier_q, ier_d, ifr_q, ifr_d, pend;
  logic            gie_q, gie_d;
  state_e          state_q, state_d;
  logic [7:0]      act_q, act_d;
  logic            irq_q, irq_d;
  logic [15:0]     irq_addr_q, irq_addr_d;

  logic [7:0]      reg_off, win, ifr_ext, rd;
  logic            reg_hit, wr_ier, wr_ifr, wr_icr;

  irq_sync_edge #(.W(NSRC)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (src),
    .rise    (src_rise)
  );

  // Register decode, read mux and register-file next state
  always_comb begin
    reg_off = io_addr - IO_BASE;
    reg_hit = (reg_off < 8'd4);
    wr_ier  = io_we && reg_hit && (reg_off[1:0] == OFF_IER);
    wr_ifr  = io_we && reg_hit && (reg_off[1:0] == OFF_IFR);
    wr_icr  = io_we && reg_hit && (reg_off[1:0] == OFF_ICR);

    ier_d = wr_ier ? io_wdata[NSRC-1:0] : ier_q;
    // A same-cycle edge re-sets a bit that software is clearing
    ifr_d = (ifr_q & ~(wr_ifr ? io_wdata[NSRC-1:0] : '0)) | src_rise;
    gie_d = wr_icr ? io_wdata[ICR_GIE] : gie_q;

    rd = 8'h00;
    if (io_re && reg_hit) begin
      case (reg_off[1:0])
        OFF_IER: rd[NSRC-1:0] = ier_q;
        OFF_IFR: rd[NSRC-1:0] = ifr_q;
        OFF_ICR: begin
          rd[ICR_GIE]  = gie_q;
          rd[ICR_BUSY] = (state_q != ST_IDLE);
        end
        default: rd = act_q;
      endcase
    end
    io_rdata = rd;
  end

  // Fixed priority: lowest pending index wins
  always_comb begin
    pend = ifr_q & ier_q;
    win  = ACT_NONE;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend[i]) win = 8'(i);
    end
    ifr_ext = 8'h00;
    ifr_ext[NSRC-1:0] = ifr_q;
  end

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    irq_addr_d = irq_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (gie_q && (pend != '0)) begin
          state_d    = ST_REQ;
          act_d      = win;
          irq_addr_d = VEC_BASE + 16'(win) * 16'(VEC_STRIDE);
        end
      end
      ST_REQ:  state_d = ST_SERV;
      ST_SERV: begin
        // Only software clearing the in-service flag ends service
        if (!ifr_ext[act_q[2:0]]) begin
          state_d = ST_GAP;
          act_d   = ACT_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    irq_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ier_q      <= '0;
      ifr_q      <= '0;
      gie_q      <= 1'b0;
      state_q    <= ST_IDLE;
      act_q      <= ACT_NONE;
      irq_q      <= 1'b0;
      irq_addr_q <= 16'h0000;
    end else begin
      ier_q      <= ier_d;
      ifr_q      <= ifr_d;
      gie_q      <= gie_d;
      state_q    <= state_d;
      act_q      <= act_d;
      irq_q      <= irq_d;
      irq_addr_q <= irq_addr_d;
    end
  end

  assign irq      = irq_q;
  assign irq_addr = irq_addr_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register access, arbitration, masking,
// set-wins-over-clear and reset during a request.
module tb_irq_ctrl;

  logic        clock;
  logic        reset_n;
  logic [7:0]  src;
  logic [7:0]  io_addr;
  logic        io_re;
  logic        io_we;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic        irq;
  logic [15:0] irq_addr;

  int vectors = 0;
  int miscompares = 0;

  irq_ctrl dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .src      (src),
    .io_addr  (io_addr),
    .io_re    (io_re),
    .io_we    (io_we),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .irq      (irq),
    .irq_addr (irq_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    io_addr  = a;
    io_wdata = d;
    io_we    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    io_we    = 1'b0;
    io_addr  = 8'h00;
    io_wdata = 8'h00;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    io_addr = a;
    io_re   = 1'b1;
    #1 d = io_rdata;
    io_re   = 1'b0;
    io_addr = 8'h00;
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  initial begin
    reset_n  = 1'b0;
    src      = 8'h00;
    io_addr  = 8'h00;
    io_re    = 1'b0;
    io_we    = 1'b0;
    io_wdata = 8'h00;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);

    // Reset values
    rd_check("rst_ier", 8'h38, 8'h00);
    rd_check("rst_ifr", 8'h39, 8'h00);
    rd_check("rst_icr", 8'h3A, 8'h00);
    rd_check("rst_act", 8'h3B, 8'hFF);
    check("rst_irq", {15'h0, irq}, 16'h0000);
    check("rst_irq_addr", irq_addr, 16'h0000);
    io_addr = 8'h3B; io_re = 1'b0; #1;
    check("rdata_no_re", {8'h00, io_rdata}, 16'h0000);
    io_addr = 8'h40; io_re = 1'b1; #1;
    check("rdata_unmapped", {8'h00, io_rdata}, 16'h0000);
    io_re = 1'b0; io_addr = 8'h00;

    // Single source 0 request and service
    io_write(8'h38, 8'h01);
    io_write(8'h3A, 8'h01);
    src = 8'h01;
    cyc(2);
    rd_check("s0_ifr_early", 8'h39, 8'h00);
    cyc(1);
    rd_check("s0_ifr_set", 8'h39, 8'h01);
    check("s0_irq_pre", {15'h0, irq}, 16'h0000);
    cyc(1);
    check("s0_irq_pulse", {15'h0, irq}, 16'h0001);
    check("s0_addr", irq_addr, 16'h0002);
    rd_check("s0_act", 8'h3B, 8'h00);
    rd_check("s0_busy", 8'h3A, 8'h81);
    cyc(1);
    check("s0_irq_drop", {15'h0, irq}, 16'h0000);
    io_write(8'h39, 8'h01);
    rd_check("s0_act_serv", 8'h3B, 8'h00);
    cyc(1);
    rd_check("s0_act_none", 8'h3B, 8'hFF);
    rd_check("s0_busy_gap", 8'h3A, 8'h81);
    cyc(1);
    rd_check("s0_idle", 8'h3A, 8'h01);
    check("s0_no_irq", {15'h0, irq}, 16'h0000);

    // Sources 5 and 2 together: 2 first, then 5
    io_write(8'h38, 8'hFF);
    src = 8'h25;
    cyc(3);
    rd_check("pr_ifr", 8'h39, 8'h24);
    cyc(1);
    check("pr_irq1", {15'h0, irq}, 16'h0001);
    check("pr_addr1", irq_addr, 16'h0006);
    rd_check("pr_act1", 8'h3B, 8'h02);
    cyc(1);
    io_write(8'h39, 8'h04);
    cyc(2);
    check("pr_gap_no_irq", {15'h0, irq}, 16'h0000);
    check("pr_addr_held", irq_addr, 16'h0006);
    cyc(1);
    check("pr_irq2", {15'h0, irq}, 16'h0001);
    check("pr_addr2", irq_addr, 16'h000C);
    rd_check("pr_act2", 8'h3B, 8'h05);
    cyc(1);
    io_write(8'h39, 8'h20);
    cyc(2);
    rd_check("pr_ifr_clr", 8'h39, 8'h00);
    src = 8'h00;
    cyc(3);

    // GIE off: pending but masked globally
    io_write(8'h3A, 8'h00);
    io_write(8'h38, 8'h08);
    src = 8'h08;
    cyc(1);
    src = 8'h00;
    cyc(3);
    rd_check("gie_ifr", 8'h39, 8'h08);
    cyc(3);
    check("gie_no_irq", {15'h0, irq}, 16'h0000);
    rd_check("gie_idle", 8'h3A, 8'h00);
    io_write(8'h3A, 8'h01);
    check("gie_irq_pre", {15'h0, irq}, 16'h0000);
    cyc(1);
    check("gie_irq", {15'h0, irq}, 16'h0001);
    check("gie_addr", irq_addr, 16'h0008);
    cyc(1);
    io_write(8'h39, 8'h08);
    cyc(2);

    // Edge and W1C on the same bit in the same cycle
    src = 8'h02;
    cyc(2);
    io_write(8'h39, 8'h02);
    rd_check("setwins_ifr", 8'h39, 8'h02);
    io_write(8'h39, 8'h02);
    rd_check("w1c_ifr", 8'h39, 8'h00);
    check("setwins_no_irq", {15'h0, irq}, 16'h0000);
    src = 8'h00;
    cyc(2);

    // Reset asserted during REQ
    src = 8'h08;
    cyc(3);
    rd_check("rr_ifr", 8'h39, 8'h08);
    cyc(1);
    check("rr_irq", {15'h0, irq}, 16'h0001);
    reset_n = 1'b0;
    src = 8'h00;
    #1;
    check("rr_irq_trunc", {15'h0, irq}, 16'h0000);
    check("rr_addr_rst", irq_addr, 16'h0000);
    cyc(2);
    reset_n = 1'b1;
    rd_check("rr_ier", 8'h38, 8'h00);
    rd_check("rr_ifr0", 8'h39, 8'h00);
    rd_check("rr_icr", 8'h3A, 8'h00);
    rd_check("rr_act", 8'h3B, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("rr_quiet", {15'h0, irq}, 16'h0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
